// File: rtl/tvip_clock_divider.sv
// Multi-channel programmable clock generator with a per-channel rise-counting wait.
// Optional macro TVIP_CLOCK_DIVIDER_IMMEDIATE_UPDATE_EN: SET_PERIOD on a running channel takes effect at once.
module tvip_clock_divider #(
  parameter  int CHANNELS   = 4,
  parameter  int DIV_WIDTH  = 16,
  parameter  int WAIT_WIDTH = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int VAL_W      = (DIV_WIDTH > WAIT_WIDTH) ? DIV_WIDTH : WAIT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_channel,
  input  logic [VAL_W-1:0]    cmd_value,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] clk_out_n,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] wait_busy,
  output logic [CHANNELS-1:0] wait_done
);

  typedef enum logic [1:0] {
    OP_START      = 2'd0,
    OP_STOP       = 2'd1,
    OP_SET_PERIOD = 2'd2,
    OP_WAIT       = 2'd3
  } op_e;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [VAL_W-1:0] v);
    logic [DIV_WIDTH-1:0] t;
    t = v[DIV_WIDTH-1:0];
    return (t == '0) ? DIV_WIDTH'(1) : t;
  endfunction

  op_e                  op;
  logic                 cmd_take;
  logic [DIV_WIDTH-1:0] div_val;
  logic [WAIT_WIDTH-1:0] wait_val;
  logic [CHANNELS-1:0]  sel;
  logic [CHANNELS-1:0]  wait_hold;

  logic [CHANNELS-1:0]   clk_q, clk_d;
  logic [CHANNELS-1:0]   run_q, run_d;
  logic [CHANNELS-1:0]   busy_q, busy_d;
  logic [CHANNELS-1:0]   done_q, done_d;
  logic [DIV_WIDTH-1:0]  h_q    [CHANNELS];
  logic [DIV_WIDTH-1:0]  h_d    [CHANNELS];
  logic [DIV_WIDTH-1:0]  p_q    [CHANNELS];
  logic [DIV_WIDTH-1:0]  p_d    [CHANNELS];
  logic [DIV_WIDTH-1:0]  cnt_q  [CHANNELS];
  logic [DIV_WIDTH-1:0]  cnt_d  [CHANNELS];
  logic [WAIT_WIDTH-1:0] wrem_q [CHANNELS];
  logic [WAIT_WIDTH-1:0] wrem_d [CHANNELS];

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !rst;
  assign cmd_take  = cmd_valid & cmd_ready;
  assign div_val   = clamp_div(cmd_value);
  assign wait_val  = cmd_value[WAIT_WIDTH-1:0];

  // Channel decode; out-of-range channel numbers match nothing and are dropped.
  always_comb begin
    sel       = '0;
    wait_hold = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel[c]       = cmd_take && (int'(cmd_channel) == c);
      wait_hold[c] = sel[c] && (op == OP_STOP || op == OP_WAIT);
    end
  end

  always_comb begin
    clk_d  = clk_q;
    run_d  = run_q;
    busy_d = busy_q;
    done_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      h_d[c]    = h_q[c];
      p_d[c]    = p_q[c];
      cnt_d[c]  = cnt_q[c];
      wrem_d[c] = wrem_q[c];

      if (run_q[c]) begin
        if (cnt_q[c] == h_q[c] - DIV_WIDTH'(1)) begin
          clk_d[c] = ~clk_q[c];
          cnt_d[c] = '0;
          h_d[c]   = p_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + DIV_WIDTH'(1);
        end
      end

      if (sel[c]) begin
        case (op)
          OP_START: begin
            h_d[c]   = div_val;
            p_d[c]   = div_val;
            cnt_d[c] = '0;
            run_d[c] = 1'b1;
            clk_d[c] = 1'b1;
          end
          OP_STOP: begin
            run_d[c]  = 1'b0;
            clk_d[c]  = 1'b0;
            cnt_d[c]  = '0;
            busy_d[c] = 1'b0;
            wrem_d[c] = '0;
          end
          OP_SET_PERIOD: begin
            p_d[c] = div_val;
`ifdef TVIP_CLOCK_DIVIDER_IMMEDIATE_UPDATE_EN
            if (run_q[c]) begin
              h_d[c]   = div_val;
              cnt_d[c] = '0;
            end
`endif
          end
          OP_WAIT: begin
            if (wait_val == '0) begin
              busy_d[c] = 1'b0;
              done_d[c] = 1'b1;
              wrem_d[c] = '0;
            end else begin
              busy_d[c] = 1'b1;
              wrem_d[c] = wait_val;
            end
          end
        endcase
      end

      // A rising clk_out consumes one count unless a STOP/WAIT on this edge overrides it.
      if (!wait_hold[c] && busy_q[c] && clk_d[c] && !clk_q[c]) begin
        if (wrem_q[c] == WAIT_WIDTH'(1)) begin
          busy_d[c] = 1'b0;
          done_d[c] = 1'b1;
          wrem_d[c] = '0;
        end else begin
          wrem_d[c] = wrem_q[c] - WAIT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q  <= '0;
      run_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        h_q[c]    <= DIV_WIDTH'(1);
        p_q[c]    <= DIV_WIDTH'(1);
        cnt_q[c]  <= '0;
        wrem_q[c] <= '0;
      end
    end else begin
      clk_q  <= clk_d;
      run_q  <= run_d;
      busy_q <= busy_d;
      done_q <= done_d;
      for (int c = 0; c < CHANNELS; c++) begin
        h_q[c]    <= h_d[c];
        p_q[c]    <= p_d[c];
        cnt_q[c]  <= cnt_d[c];
        wrem_q[c] <= wrem_d[c];
      end
    end
  end

  assign clk_out   = clk_q;
  assign clk_out_n = ~clk_q;
  assign running   = run_q;
  assign wait_busy = busy_q;
  assign wait_done = done_q;

endmodule

// File: tb/tb_tvip_clock_divider.sv
// Directed testbench for tvip_clock_divider with three channels (channel 3 is out of range).
module tb_tvip_clock_divider;

  localparam int CH = 3;
  localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_SET = 2'd2, OP_WAIT = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [1:0]    cmd_channel = 2'd0;
  logic [15:0]   cmd_value = 16'd0;
  logic [CH-1:0] clk_out, clk_out_n, running, wait_busy, wait_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int s0, s1, s2, s;

  tvip_clock_divider #(.CHANNELS(CH), .DIV_WIDTH(16), .WAIT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_channel(cmd_channel), .cmd_value(cmd_value),
    .clk_out(clk_out), .clk_out_n(clk_out_n), .running(running),
    .wait_busy(wait_busy), .wait_done(wait_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int ch, input int val);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_channel = 2'(ch);
    cmd_value   = 16'(val);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({clk_out, clk_out_n, running, wait_busy, wait_done} !== {3'b000, 3'b111, 9'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {clk_out, clk_out_n, running, wait_busy, wait_done}, {3'b000, 3'b111, 9'b0});
    end
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0", cmd_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_ignored_channel();
    issue(OP_START, 3, 4);
    n_checks++;
    if ({running, clk_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL ignored_start: got %b expected %b", {running, clk_out}, 6'b0);
    end
    issue(OP_WAIT, 3, 0);
    n_checks++;
    if ({wait_busy, wait_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL ignored_wait: got %b expected %b", {wait_busy, wait_done}, 6'b0);
    end
  endtask

  task automatic test_start_ch0();
    logic e;
    issue(OP_START, 0, 3);
    s0 = cyc;
    n_checks++;
    if (running[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL start_running: got %b expected 1", running[0]);
    end
    for (int i = 0; i < 12; i++) begin
      e = ((i / 3) % 2) == 0;
      n_checks++;
      if ({clk_out[0], clk_out_n[0]} !== {e, ~e}) begin
        n_fail++;
        $display("FAIL start_wave k=%0d: got %b expected %b", i, {clk_out[0], clk_out_n[0]}, {e, ~e});
      end
      tick();
    end
  endtask

  task automatic test_multi_channel();
    logic [2:0] e;
    issue(OP_START, 1, 1);
    s1 = cyc;
    issue(OP_START, 2, 5);
    s2 = cyc;
    n_checks++;
    if (running !== 3'b111) begin
      n_fail++;
      $display("FAIL multi_running: got %b expected 111", running);
    end
    for (int i = 0; i < 20; i++) begin
      e[0] = (((cyc - s0) / 3) % 2) == 0;
      e[1] = ((cyc - s1) % 2) == 0;
      e[2] = (((cyc - s2) / 5) % 2) == 0;
      n_checks++;
      if (clk_out !== e) begin
        n_fail++;
        $display("FAIL multi_wave t=%0d: got %b expected %b", cyc, clk_out, e);
      end
      tick();
    end
  endtask

  task automatic test_set_period();
    int k;
    logic e;
    issue(OP_START, 0, 4);
    s = cyc;
    tick();
    tick();
    issue(OP_SET, 0, 2);
    k = cyc - s;
    while (k <= 13) begin
`ifdef TVIP_CLOCK_DIVIDER_IMMEDIATE_UPDATE_EN
      e = (k < 5) ? 1'b1 : (((k - 5) / 2) % 2) != 0;
`else
      e = (k < 4) ? 1'b1 : (((k - 4) / 2) % 2) != 0;
`endif
      n_checks++;
      if (clk_out[0] !== e) begin
        n_fail++;
        $display("FAIL set_period k=%0d: got %b expected %b", k, clk_out[0], e);
      end
      tick();
      k = cyc - s;
    end
  endtask

  task automatic test_set_on_toggle();
    logic [8:0] tbl;
`ifdef TVIP_CLOCK_DIVIDER_IMMEDIATE_UPDATE_EN
    tbl = 9'b000111000;
`else
    tbl = 9'b001110001;
`endif
    issue(OP_START, 2, 2);
    tick();
    issue(OP_SET, 2, 3);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (clk_out[2] !== tbl[8-i]) begin
        n_fail++;
        $display("FAIL set_on_toggle k=%0d: got %b expected %b", i + 2, clk_out[2], tbl[8-i]);
      end
      tick();
    end
  endtask

  task automatic test_wait();
    int k;
    int done_at;
    issue(OP_START, 0, 2);
    s = cyc;
    issue(OP_WAIT, 0, 3);
    k = cyc - s;
    while (k <= 13) begin
      n_checks++;
      if ({wait_busy[0], wait_done[0]} !== {k < 12, k == 12}) begin
        n_fail++;
        $display("FAIL wait3 k=%0d: got %b expected %b", k, {wait_busy[0], wait_done[0]}, {k < 12, k == 12});
      end
      tick();
      k = cyc - s;
    end
    issue(OP_WAIT, 0, 0);
    n_checks++;
    if ({wait_busy[0], wait_done[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL wait0_pulse: got %b expected 01", {wait_busy[0], wait_done[0]});
    end
    tick();
    n_checks++;
    if (wait_done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait0_single: got %b expected 0", wait_done[0]);
    end
    issue(OP_WAIT, 0, 2);
    k = cyc - s;
    while (k < 23) begin
      n_checks++;
      if ({wait_busy[0], wait_done[0]} !== 2'b10) begin
        n_fail++;
        $display("FAIL wait2 k=%0d: got %b expected 10", k, {wait_busy[0], wait_done[0]});
      end
      tick();
      k = cyc - s;
    end
    issue(OP_WAIT, 0, 1);
    done_at = 28;
    k = cyc - s;
    while (k <= 29) begin
      n_checks++;
      if ({wait_busy[0], wait_done[0]} !== {k < done_at, k == done_at}) begin
        n_fail++;
        $display("FAIL wait_replace k=%0d: got %b expected %b", k,
                 {wait_busy[0], wait_done[0]}, {k < done_at, k == done_at});
      end
      tick();
      k = cyc - s;
    end
  endtask

  task automatic test_stop_abort();
    issue(OP_WAIT, 0, 5);
    n_checks++;
    if (wait_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait5_busy: got %b expected 1", wait_busy[0]);
    end
    tick();
    tick();
    tick();
    issue(OP_STOP, 0, 0);
    n_checks++;
    if ({clk_out[0], running[0], wait_busy[0], wait_done[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL stop_state: got %b expected 0000",
               {clk_out[0], running[0], wait_busy[0], wait_done[0]});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({clk_out[0], wait_busy[0], wait_done[0]} !== 3'b000) begin
        n_fail++;
        $display("FAIL stop_quiet i=%0d: got %b expected 000", i, {clk_out[0], wait_busy[0], wait_done[0]});
      end
    end
  endtask

  task automatic test_reset_midop();
    logic e;
    issue(OP_START, 0, 3);
    issue(OP_WAIT, 1, 4);
    n_checks++;
    if ({running, wait_busy[1]} !== 4'b1111) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected 1111", {running, wait_busy[1]});
    end
    rst         = 1'b1;
    cmd_valid   = 1'b1;
    cmd_op      = OP_START;
    cmd_channel = 2'd0;
    cmd_value   = 16'd7;
    tick();
    n_checks++;
    if ({clk_out, clk_out_n, running, wait_busy, wait_done, cmd_ready} !== {3'b000, 3'b111, 9'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_reset: got %b expected %b",
               {clk_out, clk_out_n, running, wait_busy, wait_done, cmd_ready}, {3'b000, 3'b111, 9'b0, 1'b0});
    end
    tick();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    n_checks++;
    if ({running, clk_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL dropped_cmd: got %b expected %b", {running, clk_out}, 6'b0);
    end
    issue(OP_START, 0, 0);
    s = cyc;
    for (int i = 0; i < 6; i++) begin
      e = ((cyc - s) % 2) == 0;
      n_checks++;
      if ({running[0], clk_out[0]} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL zero_period i=%0d: got %b expected %b", i, {running[0], clk_out[0]}, {1'b1, e});
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ignored_channel();
    test_start_ch0();
    test_multi_channel();
    test_set_on_toggle();
    test_set_period();
    test_wait();
    test_stop_abort();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
